// File: rtl/fetch_queue_if.sv
// Fetch front end signal bundle: redirect input, instruction memory
// request/response handshake and the IF/ID-facing output handshake.
interface fetch_queue_if #(
    parameter int LENGTH = 32
);
    logic              redirect;
    logic [LENGTH-1:0] redirect_pc;
    logic              imem_req_valid;
    logic [LENGTH-1:0] imem_req_addr;
    logic              imem_req_ready;
    logic              imem_resp_valid;
    logic [LENGTH-1:0] imem_resp_data;
    logic              out_valid;
    logic [LENGTH-1:0] out_instr;
    logic [LENGTH-1:0] out_pc_4;
    logic              out_ready;

    modport slave (
        input  redirect,
        input  redirect_pc,
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        output out_valid,
        output out_instr,
        output out_pc_4,
        input  out_ready
    );

    modport master (
        output redirect,
        output redirect_pc,
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        input  out_valid,
        input  out_instr,
        input  out_pc_4,
        output out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues in-order word
// reads and buffers returned instructions ahead of the IF/ID register.
module fetch_queue #(
    parameter int                LENGTH   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [LENGTH-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          rst,
    fetch_queue_if.slave fq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]     FULL = CW'(DEPTH);
    localparam logic [CW-1:0]     ONE  = CW'(1);
    localparam logic [PW-1:0]     STEP = PW'(1);
    localparam logic [LENGTH-1:0] WORD = LENGTH'(4);

    typedef struct packed {
        logic [LENGTH-1:0] instr;
        logic [LENGTH-1:0] pc4;
    } entry_t;

    entry_t            entries [DEPTH];
    logic [LENGTH-1:0] fetchPc;
    logic [LENGTH-1:0] fetchPcNext;
    logic [LENGTH-1:0] respPc;
    logic [LENGTH-1:0] respPcNext;
    logic [CW-1:0]     count;
    logic [CW-1:0]     countNext;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     outstandingNext;
    logic [CW-1:0]     drop;
    logic [CW-1:0]     dropNext;
    logic [CW-1:0]     inFlight;
    logic [PW-1:0]     rdPtr;
    logic [PW-1:0]     rdPtrNext;
    logic [PW-1:0]     wrPtr;
    logic [PW-1:0]     wrPtrNext;
    logic [LENGTH-1:0] target;
    logic              reqValid;
    logic              reqFire;
    logic              respFire;
    logic              push;
    logic              pop;

    // Credits cover both buffered entries and requests still in memory.
    assign inFlight = count + outstanding;
    assign target   = {fq.redirect_pc[LENGTH-1:2], 2'b00};
    assign reqValid = rst && !fq.redirect
                    && (inFlight < FULL) && (drop == '0);
    assign reqFire  = reqValid && fq.imem_req_ready;
    assign respFire = fq.imem_resp_valid && (outstanding != '0);
    assign push     = respFire && (drop == '0) && !fq.redirect;
    assign pop      = (count != '0) && fq.out_ready && !fq.redirect;

    always_comb begin
        fetchPcNext     = fetchPc;
        respPcNext      = respPc;
        rdPtrNext       = rdPtr;
        wrPtrNext       = wrPtr;
        countNext       = count;
        dropNext        = drop;
        outstandingNext = outstanding + CW'(reqFire) - CW'(respFire);
        if (fq.redirect) begin
            fetchPcNext = target;
            respPcNext  = target;
            rdPtrNext   = '0;
            wrPtrNext   = '0;
            countNext   = '0;
            // Everything still in memory after this edge belongs to the old path.
            dropNext    = outstandingNext;
        end else begin
            if (reqFire) begin
                fetchPcNext = fetchPc + WORD;
            end
            if (respFire && (drop != '0)) begin
                dropNext = drop - ONE;
            end
            if (push) begin
                respPcNext = respPc + WORD;
                wrPtrNext  = wrPtr + STEP;
            end
            if (pop) begin
                rdPtrNext = rdPtr + STEP;
            end
            countNext = count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetchPc     <= RESET_PC;
            respPc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            rdPtr       <= '0;
            wrPtr       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            fetchPc     <= fetchPcNext;
            respPc      <= respPcNext;
            count       <= countNext;
            outstanding <= outstandingNext;
            drop        <= dropNext;
            rdPtr       <= rdPtrNext;
            wrPtr       <= wrPtrNext;
            if (push) begin
                entries[wrPtr] <= '{instr: fq.imem_resp_data,
                                    pc4:   respPc + WORD};
            end
        end
    end

    assign fq.imem_req_valid = reqValid;
    assign fq.imem_req_addr  = fetchPc;
    assign fq.out_valid      = (count != '0);
    assign fq.out_instr      = entries[rdPtr].instr;
    assign fq.out_pc_4       = entries[rdPtr].pc4;
endmodule
